// File: rtl/pc_gen_pkg.sv
// Shared fetch-address map for the pipelined MIPS core (PC, NPC, CP0, IM blocks).
// Names carry a PC_ prefix so modules can re-expose them as parameters without clashing.
package pc_gen_pkg;

    localparam int          PC_W          = 32;
    localparam logic [31:0] PC_RESET_ADDR = 32'h0000_3000;
    localparam logic [31:0] PC_EXC_ADDR   = 32'h0000_4180;
    localparam logic [31:0] PC_IMEM_BASE  = 32'h0000_3000;
    localparam logic [31:0] PC_IMEM_BYTES = 32'h0000_3000;

endpackage

// File: rtl/pc_range_check.sv
// Flags an address that is not word aligned or lies outside [BASE, BASE+BYTES).
module pc_range_check
    import pc_gen_pkg::*;
#(
    parameter int               WIDTH = PC_W,
    parameter logic [WIDTH-1:0] BASE  = WIDTH'(PC_IMEM_BASE),
    parameter logic [WIDTH-1:0] BYTES = WIDTH'(PC_IMEM_BYTES)
) (
    input  logic [WIDTH-1:0] addr,
    output logic             err
);

    // One extra bit keeps BASE+BYTES from wrapping for windows that reach the top of memory.
    localparam logic [WIDTH:0] LIMIT = {1'b0, BASE} + {1'b0, BYTES};

    logic misaligned;
    logic below_base;
    logic above_limit;

    assign misaligned  = (addr[1:0] != 2'b00);
    assign below_base  = (addr < BASE);
    assign above_limit = ({1'b0, addr} >= LIMIT);
    assign err         = misaligned | below_base | above_limit;

endmodule

// File: rtl/pc_gen.sv
// Fetch program counter: sequential / redirect / exception / eret selection,
// with a one-entry buffer that keeps a redirect arriving during a stall.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int               WIDTH      = PC_W,
    parameter logic [WIDTH-1:0] RESET_ADDR = WIDTH'(PC_RESET_ADDR),
    parameter logic [WIDTH-1:0] EXC_ADDR   = WIDTH'(PC_EXC_ADDR),
    parameter logic [WIDTH-1:0] IMEM_BASE  = WIDTH'(PC_IMEM_BASE),
    parameter logic [WIDTH-1:0] IMEM_BYTES = WIDTH'(PC_IMEM_BYTES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_target,
    input  logic             exc_req,
    input  logic             eret_req,
    input  logic [WIDTH-1:0] epc,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             pend_valid,
    output logic             fetch_err
);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic             pend_valid_q, pend_valid_d;
    logic [WIDTH-1:0] pend_target_q, pend_target_d;

    assign pc_plus4 = pc_q + WIDTH'(4);

    // Exception and eret bypass the stall; a live redirect outranks a buffered one.
    always_comb begin
        pc_d          = pc_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        if (exc_req) begin
            pc_d         = EXC_ADDR;
            pend_valid_d = 1'b0;
        end else if (eret_req) begin
            pc_d         = epc;
            pend_valid_d = 1'b0;
        end else if (stall) begin
            if (redirect_valid) begin
                pend_target_d = redirect_target;
                pend_valid_d  = 1'b1;
            end
        end else if (redirect_valid) begin
            pc_d         = redirect_target;
            pend_valid_d = 1'b0;
        end else if (pend_valid_q) begin
            pc_d         = pend_target_q;
            pend_valid_d = 1'b0;
        end else begin
            pc_d = pc_plus4;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_ADDR;
            pend_valid_q  <= 1'b0;
            pend_target_q <= '0;
        end else begin
            pc_q          <= pc_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
        end
    end

    pc_range_check #(
        .WIDTH (WIDTH),
        .BASE  (IMEM_BASE),
        .BYTES (IMEM_BYTES)
    ) u_range_check (
        .addr (pc_q),
        .err  (fetch_err)
    );

    assign pc         = pc_q;
    assign pend_valid = pend_valid_q;

endmodule
